sprite_row_fetcher: RTL and testbench
=====================================

Name: sprite_row_fetcher

Overview:
- Read client of one 256x16 sprite ROM (16x16 sprite, RGB565 per word). Sits between the ROM and the VGA pixel mux.
- On each line_start it checks whether the sprite covers the upcoming scanline. If so, it fetches that sprite row (16 words) into a ping-pong row buffer.
- During the active line it serves one pixel per clock with a transparency flag.

Parameters:
- ROW_W, 16, sprite width in pixels; power of two.
- ROWS, 16, sprite height in rows.
- ADDR_W, 8, ROM word-address width; equals log2(ROW_W*ROWS).
- COLOR_W, 16, pixel/word width.
- TRANSPARENT, 16'hF81F, colour key; pixels equal to it are reported not valid.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- line_start  in  1  one-cycle pulse; start of the horizontal interval preceding scanline next_line
- next_line  in  10  scanline to be fetched for
- sprite_en  in  1  sprite visible; sampled at line_start
- sprite_x  in  11  left screen column; sampled at line_start
- sprite_y  in  10  top screen row; sampled at line_start
- hcount  in  11  current pixel column of the line being displayed
- rom_address  out  ADDR_W  ROM word address
- rom_chipselect  out  1  high while fetching
- rom_clken  out  1  high while fetching
- rom_readdata  in  COLOR_W  ROM data; valid one clock after address is presented
- pix_valid  out  1  sprite pixel present and not transparent
- pix_color  out  COLOR_W  sprite pixel colour
- fetch_busy  out  1  high in FETCH or DRAIN
- overrun  out  1  sticky; a fetch was aborted by line_start

Behaviour:
- Reset values: all outputs 0; state IDLE; both buffer valid flags 0; overrun 0.
- Row selection: row = next_line - sprite_y, computed 11-bit. Hit = sprite_en && next_line >= sprite_y && row < ROWS.
- ROM address = row*ROW_W + col, truncated to ADDR_W.
- ROM interface is read-only; this block drives no write signals.
- FSM states:
  - IDLE: on line_start, swap buffers. Front takes back's row data, valid flag and latched x; back_valid <= 0. If hit, latch row/x and go to FETCH with col=0. Otherwise stay in IDLE.
  - FETCH: present rom_address for col, increment col each clock. After col=ROW_W-1 is issued, go to DRAIN.
  - Captures: word for col k is written into back[k] one clock after issue.
  - DRAIN: capture the last word, set back_valid=1, go to IDLE.
- A fetch takes ROW_W+1 clocks from the line_start edge to back_valid.
- line_start while in FETCH or DRAIN:
  - Abort, set overrun=1 and back_valid=0.
  - Perform the swap; front becomes invalid.
  - Re-evaluate hit for the new next_line and restart FETCH from col 0 if hit.
- Pixel path, registered, one clock latency: outputs at t+1 reflect hcount at t.
  - d = hcount - front_x, 12-bit signed.
  - pix_valid = front_valid && 0 <= d < ROW_W && front[d] != TRANSPARENT.
  - pix_color = front[d] when pix_valid, else 0.
- Off-screen sprites: sprite_x near 2047 is not wrapped; columns past 2047 are simply never matched.
- Reset mid-fetch: immediate return to IDLE, all flags cleared.

Optional Feature:
- Macro: SPRITE_ROW_FETCHER_MIRROR_EN.
- Defined:
  - Adds input mirror_h (1 bit), sampled at line_start together with sprite_x.
  - When set, fetch column address is ROW_W-1-col while the buffer index stays col, giving a horizontally flipped row.
- Undefined: port absent; normal column order.

Decomposition:
- Package sprite_pkg:
  - state enum {IDLE, FETCH, DRAIN}
  - TRANSPARENT default
  - ROW_W/ROWS/ADDR_W/COLOR_W defaults
  - pixel_t typedef (COLOR_W bits)
- Sub-module sprite_row_buffer: 2 x ROW_W x COLOR_W ping-pong storage with write port, swap strobe, valid flags and async read.

Test Plan:
- Basic hit:
  - Stimulus: ROM word i = i; sprite_y=100, sprite_x=200, next_line=103.
  - Required: rom_address 48..63 on consecutive clocks; back_valid after 17 clocks.
  - After the next line_start, hcount=200..215 gives pix_color 48..63 one clock later; pix_valid=0 at hcount 199 and 216.
- Miss:
  - Stimulus: next_line=99 or 116 with sprite_y=100; also sprite_en=0.
  - Required: no rom_chipselect, fetch_busy=0, pix_valid=0 on the following line.
- Transparency:
  - Stimulus: ROM word 50 = 16'hF81F.
  - Required: pix_valid=0 at hcount 202 on line 103; neighbouring pixels valid.
- Overrun:
  - Stimulus: line_start, then a second line_start 5 clocks later.
  - Required: overrun=1 and stays 1; front invalid; fresh 16-word fetch restarts at col 0.
- Reset mid-fetch:
  - Stimulus: reset_n low at col 7.
  - Required: all outputs 0 immediately; no stale pixels after release.
- Mirror (macro defined):
  - Stimulus: mirror_h=1, row 3.
  - Required: addresses issue 63 down to 48; hcount=200 gives colour 63.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and default sizing for the sprite row fetcher.
// Optional build macro: SPRITE_ROW_FETCHER_MIRROR_EN (horizontal flip input).
package sprite_pkg;

   localparam int DEF_ROW_W   = 16;
   localparam int DEF_ROWS    = 16;
   localparam int DEF_ADDR_W  = 8;
   localparam int DEF_COLOR_W = 16;

   // Magenta colour key: pixels of this value are never shown.
   localparam logic [15:0] DEF_TRANSPARENT = 16'hF81F;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

   typedef logic [DEF_COLOR_W-1:0] pixel_t;

endpackage

// File: rtl/sprite_row_buffer.sv
// Ping-pong sprite row storage: the back bank is filled by the ROM fetch
// while the front bank is read combinationally by the pixel path. A swap
// strobe exchanges the banks and hands the back valid flag to the front.
module sprite_row_buffer
   import sprite_pkg::*;
#(
   parameter int ROW_W   = DEF_ROW_W,
   parameter int COLOR_W = DEF_COLOR_W,
   parameter int IDX_W   = $clog2(ROW_W)
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic               i_swap,
   input  logic               i_set_back_valid,
   input  logic               i_wr_en,
   input  logic [IDX_W-1:0]   i_wr_idx,
   input  logic [COLOR_W-1:0] i_wr_data,
   input  logic [IDX_W-1:0]   i_rd_idx,
   output logic [COLOR_W-1:0] o_rd_data,
   output logic               o_front_valid
);

   logic               r_front_sel;
   logic               r_front_valid;
   logic               r_back_valid;
   logic [COLOR_W-1:0] w_bank_rd [2];

   for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      logic [COLOR_W-1:0] r_words [ROW_W];

      // Only the bank currently acting as back accepts fetched words.
      always_ff @(posedge i_clk) begin
         if (i_wr_en && (r_front_sel != 1'(gi)))
            r_words[i_wr_idx] <= i_wr_data;
      end

      assign w_bank_rd[gi] = r_words[i_rd_idx];
   end

   // Bank select and valid flags; a swap always leaves the back invalid.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_front_sel   <= 1'b0;
         r_front_valid <= 1'b0;
         r_back_valid  <= 1'b0;
      end else if (i_swap) begin
         r_front_sel   <= ~r_front_sel;
         r_front_valid <= r_back_valid;
         r_back_valid  <= 1'b0;
      end else if (i_set_back_valid) begin
         r_back_valid  <= 1'b1;
      end
   end

   assign o_rd_data     = r_front_sel ? w_bank_rd[1] : w_bank_rd[0];
   assign o_front_valid = r_front_valid;

endmodule

// File: rtl/sprite_row_fetcher.sv
// Sprite row fetcher: on each line_start decides whether the sprite covers
// the upcoming scanline, streams that row out of the sprite ROM into the
// back half of a ping-pong buffer, and serves the front half one pixel per
// clock with transparency keying.
// Optional build macro: SPRITE_ROW_FETCHER_MIRROR_EN adds input mirror_h
// for a horizontally flipped fetch.
module sprite_row_fetcher
   import sprite_pkg::*;
#(
   parameter int                 ROW_W       = DEF_ROW_W,
   parameter int                 ROWS        = DEF_ROWS,
   parameter int                 ADDR_W      = DEF_ADDR_W,
   parameter int                 COLOR_W     = DEF_COLOR_W,
   parameter logic [COLOR_W-1:0] TRANSPARENT = COLOR_W'(DEF_TRANSPARENT)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               line_start,
   input  logic [9:0]         next_line,
   input  logic               sprite_en,
   input  logic [10:0]        sprite_x,
   input  logic [9:0]         sprite_y,
`ifdef SPRITE_ROW_FETCHER_MIRROR_EN
   input  logic               mirror_h,
`endif
   input  logic [10:0]        hcount,
   output logic [ADDR_W-1:0]  rom_address,
   output logic               rom_chipselect,
   output logic               rom_clken,
   input  logic [COLOR_W-1:0] rom_readdata,
   output logic               pix_valid,
   output logic [COLOR_W-1:0] pix_color,
   output logic               fetch_busy,
   output logic               overrun
);

   localparam int IDX_W = $clog2(ROW_W);

   state_t              r_state;
   logic [IDX_W-1:0]    r_col;
   logic [ADDR_W-1:0]   r_row;
   logic                r_mirror;
   logic [10:0]         r_back_x;
   logic [10:0]         r_front_x;
   logic                r_cap_en;
   logic [IDX_W-1:0]    r_cap_idx;
   logic [ADDR_W-1:0]   r_rom_address;
   logic                r_rom_cs;
   logic                r_overrun;
   logic                r_pix_valid;
   logic [COLOR_W-1:0]  r_pix_color;

   logic                w_mirror;
   logic [10:0]         w_row;
   logic                w_hit;
   logic [11:0]         w_d;
   logic                w_in_row;
   logic [COLOR_W-1:0]  w_front_word;
   logic                w_front_valid;
   logic                w_buf_wr_en;
   logic                w_set_back_valid;

`ifdef SPRITE_ROW_FETCHER_MIRROR_EN
   assign w_mirror = mirror_h;
`else
   assign w_mirror = 1'b0;
`endif

   // Row within the sprite for the scanline about to be displayed.
   assign w_row = {1'b0, next_line} - {1'b0, sprite_y};
   assign w_hit = sprite_en && (next_line >= sprite_y) && (w_row < 11'(ROWS));

   // ROM word address for a sprite row/column; mirroring reverses the column.
   function automatic logic [ADDR_W-1:0] rom_addr_of(
      input logic [ADDR_W-1:0] row,
      input logic [IDX_W-1:0]  col,
      input logic              mir
   );
      logic [IDX_W-1:0]        c;
      logic [ADDR_W+IDX_W-1:0] full;
      c    = mir ? ~col : col;
      full = {row, c};
      return full[ADDR_W-1:0];
   endfunction

   // Fetch sequencer: issues ROW_W addresses, tracks the one-clock ROM
   // latency for captures, and restarts on line_start in any state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= IDLE;
         r_col         <= '0;
         r_row         <= '0;
         r_mirror      <= 1'b0;
         r_back_x      <= '0;
         r_front_x     <= '0;
         r_cap_en      <= 1'b0;
         r_cap_idx     <= '0;
         r_rom_address <= '0;
         r_rom_cs      <= 1'b0;
         r_overrun     <= 1'b0;
      end else begin
         r_cap_en <= 1'b0;
         if (line_start) begin
            r_front_x <= r_back_x;
            if (r_state != IDLE)
               r_overrun <= 1'b1;
            if (w_hit) begin
               r_state       <= FETCH;
               r_col         <= '0;
               r_row         <= w_row[ADDR_W-1:0];
               r_mirror      <= w_mirror;
               r_back_x      <= sprite_x;
               r_rom_address <= rom_addr_of(w_row[ADDR_W-1:0], '0, w_mirror);
               r_rom_cs      <= 1'b1;
            end else begin
               r_state  <= IDLE;
               r_rom_cs <= 1'b0;
            end
         end else begin
            case (r_state)
               FETCH: begin
                  r_cap_en  <= 1'b1;
                  r_cap_idx <= r_col;
                  if (r_col == IDX_W'(ROW_W - 1)) begin
                     r_state  <= DRAIN;
                     r_rom_cs <= 1'b0;
                  end else begin
                     r_col         <= r_col + 1'b1;
                     r_rom_address <= rom_addr_of(r_row, r_col + 1'b1, r_mirror);
                  end
               end
               DRAIN:   r_state <= IDLE;
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   // A line_start discards any in-flight capture so the aborted row never
   // lands in the bank that is about to become front.
   assign w_buf_wr_en      = r_cap_en && !line_start;
   assign w_set_back_valid = (r_state == DRAIN) && !line_start;

   sprite_row_buffer #(
      .ROW_W   (ROW_W),
      .COLOR_W (COLOR_W),
      .IDX_W   (IDX_W)
   ) u_buf (
      .i_clk            (clk),
      .i_reset_n        (reset_n),
      .i_swap           (line_start),
      .i_set_back_valid (w_set_back_valid),
      .i_wr_en          (w_buf_wr_en),
      .i_wr_idx         (r_cap_idx),
      .i_wr_data        (rom_readdata),
      .i_rd_idx         (w_d[IDX_W-1:0]),
      .o_rd_data        (w_front_word),
      .o_front_valid    (w_front_valid)
   );

   // Offset of the current column into the sprite; negative wraps to a
   // set sign bit, so columns left of the sprite are rejected.
   assign w_d      = {1'b0, hcount} - {1'b0, r_front_x};
   assign w_in_row = !w_d[11] && (w_d < 12'(ROW_W));

   // Pixel output stage, one clock behind hcount.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pix_valid <= 1'b0;
         r_pix_color <= '0;
      end else if (w_front_valid && w_in_row && (w_front_word != TRANSPARENT)) begin
         r_pix_valid <= 1'b1;
         r_pix_color <= w_front_word;
      end else begin
         r_pix_valid <= 1'b0;
         r_pix_color <= '0;
      end
   end

   assign rom_address    = r_rom_address;
   assign rom_chipselect = r_rom_cs;
   assign rom_clken      = r_rom_cs;
   assign fetch_busy     = (r_state != IDLE);
   assign overrun        = r_overrun;
   assign pix_valid      = r_pix_valid;
   assign pix_color      = r_pix_color;

endmodule

// File: tb/tb_sprite_row_fetcher.sv
// Self-checking bench for sprite_row_fetcher: a line-level reference model
// plus directed scenarios with hand-computed expectations.
module tb_sprite_row_fetcher;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        line_start = 1'b0;
   logic [9:0]  next_line = '0;
   logic        sprite_en = 1'b0;
   logic [10:0] sprite_x = '0;
   logic [9:0]  sprite_y = '0;
   logic [10:0] hcount = '0;
   logic [7:0]  rom_address;
   logic        rom_chipselect;
   logic        rom_clken;
   logic [15:0] rom_readdata = '0;
   logic        pix_valid;
   logic [15:0] pix_color;
   logic        fetch_busy;
   logic        overrun;
`ifdef SPRITE_ROW_FETCHER_MIRROR_EN
   logic        mirror_h = 1'b0;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] rom [256];

   always #5 clk = ~clk;

   sprite_row_fetcher dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .line_start     (line_start),
      .next_line      (next_line),
      .sprite_en      (sprite_en),
      .sprite_x       (sprite_x),
      .sprite_y       (sprite_y),
`ifdef SPRITE_ROW_FETCHER_MIRROR_EN
      .mirror_h       (mirror_h),
`endif
      .hcount         (hcount),
      .rom_address    (rom_address),
      .rom_chipselect (rom_chipselect),
      .rom_clken      (rom_clken),
      .rom_readdata   (rom_readdata),
      .pix_valid      (pix_valid),
      .pix_color      (pix_color),
      .fetch_busy     (fetch_busy),
      .overrun        (overrun)
   );

   // Synchronous sprite ROM: data appears one clock after the address.
   always @(posedge clk) begin
      if (rom_chipselect && rom_clken)
         rom_readdata <= rom[rom_address];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Line-level view: a fetch started by line_start runs for 17 clocks,
   // addresses for columns 0..15 appear on clocks 0..15 after the edge, and
   // a row is displayable only if its fetch finished before the next
   // line_start.
   logic        cur_mir;
`ifdef SPRITE_ROW_FETCHER_MIRROR_EN
   assign cur_mir = mirror_h;
`else
   assign cur_mir = 1'b0;
`endif

   int          m_k = -1;
   int          m_row = 0;
   logic        m_mir = 1'b0;
   logic        m_back_valid = 1'b0;
   logic        m_front_valid = 1'b0;
   logic [10:0] m_back_x = '0;
   logic [10:0] m_front_x = '0;
   logic [15:0] m_back_w [16];
   logic [15:0] m_front_w [16];
   logic        m_overrun = 1'b0;
   logic        m_pv = 1'b0;
   logic [15:0] m_pc = '0;

   int          m_row_i;
   logic        m_hit;
   int          m_d;
   logic [7:0]  m_addr;

   always_comb begin
      m_row_i = int'(next_line) - int'(sprite_y);
      m_hit   = sprite_en && (m_row_i >= 0) && (m_row_i < 16);
      m_d     = int'(hcount) - int'(m_front_x);
      m_addr  = 8'(m_row * 16 + (m_mir ? 15 - m_k : m_k));
   end

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_k           <= -1;
         m_back_valid  <= 1'b0;
         m_front_valid <= 1'b0;
         m_overrun     <= 1'b0;
         m_pv          <= 1'b0;
         m_pc          <= '0;
      end else begin
         if (m_front_valid && m_d >= 0 && m_d < 16 && m_front_w[m_d[3:0]] != 16'hF81F) begin
            m_pv <= 1'b1;
            m_pc <= m_front_w[m_d[3:0]];
         end else begin
            m_pv <= 1'b0;
            m_pc <= '0;
         end
         if (line_start) begin
            m_front_valid <= m_back_valid;
            m_front_w     <= m_back_w;
            m_front_x     <= m_back_x;
            m_back_valid  <= 1'b0;
            if (m_k >= 0) m_overrun <= 1'b1;
            if (m_hit) begin
               m_k      <= 0;
               m_row    <= m_row_i;
               m_mir    <= cur_mir;
               m_back_x <= sprite_x;
               for (int c = 0; c < 16; c++)
                  m_back_w[c] <= rom[8'(m_row_i * 16 + (cur_mir ? 15 - c : c))];
            end else begin
               m_k <= -1;
            end
         end else if (m_k == 16) begin
            m_back_valid <= 1'b1;
            m_k          <= -1;
         end else if (m_k >= 0) begin
            m_k <= m_k + 1;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      #1;
      chk("pix_valid", pix_valid, m_pv);
      chk("pix_color", pix_color, m_pc);
      chk("fetch_busy", fetch_busy, (m_k >= 0 && m_k <= 16));
      chk("rom_chipselect", rom_chipselect, (m_k >= 0 && m_k <= 15));
      chk("rom_clken", rom_clken, (m_k >= 0 && m_k <= 15));
      chk("overrun", overrun, m_overrun);
      if (!reset_n)
         chk("rst_address", rom_address, 0);
      else if (m_k >= 0 && m_k <= 15)
         chk("rom_address", rom_address, m_addr);
   end

   // ---------------- stimulus helpers ----------------
   task automatic pulse(input int nl);
      @(negedge clk);
      line_start = 1'b1;
      next_line  = 10'(nl);
      $display("line_start next_line=%0d sprite_en=%0d x=%0d y=%0d", nl, sprite_en, sprite_x, sprite_y);
      @(negedge clk);
      line_start = 1'b0;
   endtask

   task automatic pix_at(input int h, input logic ev, input logic [15:0] ec);
      @(negedge clk);
      hcount = 11'(h);
      @(negedge clk);
      #1;
      chk($sformatf("lit_pix_valid@%0d", h), pix_valid, ev);
      chk($sformatf("lit_pix_color@%0d", h), pix_color, ec);
      hcount = '0;
   endtask

   task automatic sweep(input int lo, input int hi);
      for (int h = lo; h <= hi; h++) begin
         @(negedge clk);
         hcount = 11'(h);
      end
      @(negedge clk);
      hcount = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios ----------------
   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 16'(i);
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_addr", rom_address, 0);
      chk("reset_cs", rom_chipselect, 0);
      chk("reset_pix", pix_valid, 0);
      chk("reset_overrun", overrun, 0);
      #1 reset_n = 1'b1;

      sprite_en = 1'b1;
      sprite_x  = 11'd200;
      sprite_y  = 10'd100;

      // Basic hit: row 3 -> addresses 48..63
      pulse(103);
      #1 chk("hit_first_addr", rom_address, 48);
      chk("hit_busy", fetch_busy, 1);
      repeat (15) @(negedge clk);
      #1 chk("hit_last_addr", rom_address, 63);
      @(negedge clk);
      #1 chk("hit_drain_busy", fetch_busy, 1);
      chk("hit_drain_cs", rom_chipselect, 0);
      @(negedge clk);
      #1 chk("hit_done_busy", fetch_busy, 0);
      pulse(104);
      pix_at(199, 1'b0, 16'd0);
      pix_at(200, 1'b1, 16'd48);
      pix_at(215, 1'b1, 16'd63);
      pix_at(216, 1'b0, 16'd0);
      sweep(195, 220);
      repeat (20) @(negedge clk);

      // Misses above, below and with the sprite disabled
      pulse(99);
      #1 chk("miss_above_cs", rom_chipselect, 0);
      chk("miss_above_busy", fetch_busy, 0);
      pulse(116);
      #1 chk("miss_below_cs", rom_chipselect, 0);
      pix_at(205, 1'b0, 16'd0);
      sprite_en = 1'b0;
      pulse(103);
      #1 chk("miss_disabled_busy", fetch_busy, 0);
      sprite_en = 1'b1;
      sweep(198, 218);

      // Transparency: word 50 is the colour key
      rom[50] = 16'hF81F;
      pulse(103);
      repeat (20) @(negedge clk);
      pulse(600);
      pix_at(201, 1'b1, 16'd49);
      pix_at(202, 1'b0, 16'd0);
      pix_at(203, 1'b1, 16'd51);
      sweep(198, 218);

      // Overrun: second line_start five clocks after the first
      pulse(103);
      repeat (3) @(negedge clk);
      pulse(105);
      #1 chk("ovr_restart_addr", rom_address, 80);
      chk("ovr_flag", overrun, 1);
      pix_at(205, 1'b0, 16'd0);
      repeat (20) @(negedge clk);
      #1 chk("ovr_sticky", overrun, 1);
      pulse(600);
      pix_at(200, 1'b1, 16'd80);
      sweep(198, 218);

      // Reset in the middle of a fetch
      pulse(103);
      repeat (7) @(negedge clk);
      #1 chk("rst_mid_addr", rom_address, 55);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_mid_addr0", rom_address, 0);
      chk("rst_mid_cs", rom_chipselect, 0);
      chk("rst_mid_busy", fetch_busy, 0);
      chk("rst_mid_overrun", overrun, 0);
      chk("rst_mid_pix", pix_valid, 0);
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b1;
      pulse(600);
      pix_at(205, 1'b0, 16'd0);
      sweep(198, 218);

`ifdef SPRITE_ROW_FETCHER_MIRROR_EN
      // Mirrored fetch of row 3
      mirror_h = 1'b1;
      pulse(103);
      mirror_h = 1'b0;
      #1 chk("mir_first_addr", rom_address, 63);
      repeat (15) @(negedge clk);
      #1 chk("mir_last_addr", rom_address, 48);
      repeat (3) @(negedge clk);
      pulse(600);
      pix_at(200, 1'b1, 16'd63);
      pix_at(213, 1'b0, 16'd0);
      sweep(198, 218);
`endif

      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
